// File: rtl/l1_mem_req_arbiter.sv
// l1_mem_req_arbiter: shares the L1-to-memory request port between the I-cache
// refill (IC), D-cache read miss (DR) and D-cache write-buffer store (DW) paths.
// Round-robin arbitration feeds a registered output stage. Stores are throttled
// to MaxOutstandingStores unacknowledged requests. Responses are routed back to
// their requester by source ID.
//
// Ports:
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   ic_req_*                      I-cache request (valid/ready, addr, tid)
//   dr_req_*                      D-cache read-miss request (valid/ready, addr, tid)
//   dw_req_*                      store request (valid/ready, addr, data, be, tid)
//   mem_req_*                     registered request to the memory adapter
//   mem_rtrn_valid_i/src_i        response from memory, tagged with its source
//   ic_rtrn_valid_o, dr_rtrn_valid_o, dw_ack_o   demultiplexed responses
//   store_cnt_o                   outstanding-store count
//   stores_idle_o                 no store held in the output stage or outstanding
module l1_mem_req_arbiter #(
  parameter int unsigned AddrWidth            = 64,
  parameter int unsigned DataWidth            = 64,
  parameter int unsigned TidWidth             = 2,
  parameter int unsigned MaxOutstandingStores = 7
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   ic_req_valid_i,
  output logic                   ic_req_ready_o,
  input  logic [AddrWidth-1:0]   ic_req_addr_i,
  input  logic [TidWidth-1:0]    ic_req_tid_i,
  input  logic                   dr_req_valid_i,
  output logic                   dr_req_ready_o,
  input  logic [AddrWidth-1:0]   dr_req_addr_i,
  input  logic [TidWidth-1:0]    dr_req_tid_i,
  input  logic                   dw_req_valid_i,
  output logic                   dw_req_ready_o,
  input  logic [AddrWidth-1:0]   dw_req_addr_i,
  input  logic [DataWidth-1:0]   dw_req_data_i,
  input  logic [DataWidth/8-1:0] dw_req_be_i,
  input  logic [TidWidth-1:0]    dw_req_tid_i,
  output logic                   mem_req_valid_o,
  input  logic                   mem_req_ready_i,
  output logic [1:0]             mem_req_src_o,
  output logic                   mem_req_we_o,
  output logic [AddrWidth-1:0]   mem_req_addr_o,
  output logic [DataWidth-1:0]   mem_req_data_o,
  output logic [DataWidth/8-1:0] mem_req_be_o,
  output logic [TidWidth-1:0]    mem_req_tid_o,
  input  logic                   mem_rtrn_valid_i,
  input  logic [1:0]             mem_rtrn_src_i,
  output logic                   ic_rtrn_valid_o,
  output logic                   dr_rtrn_valid_o,
  output logic                   dw_ack_o,
  output logic [7:0]             store_cnt_o,
  output logic                   stores_idle_o
);

  localparam int unsigned BeWidth  = DataWidth / 8;
  localparam int unsigned CntWidth = 8;
  localparam logic [1:0]  SrcIc    = 2'd0;
  localparam logic [1:0]  SrcDr    = 2'd1;
  localparam logic [1:0]  SrcDw    = 2'd2;

  logic [1:0]          rr_ptr_q;
  logic [1:0]          rr_ptr_d;
  logic [CntWidth-1:0] store_cnt_q;
  logic [2:0]          elig;
  logic                any_elig;
  logic [1:0]          winner;
  logic                load_en;
  logic                grant;
  logic                store_inc;
  logic                store_ack;

  // Eligibility; stores are held off once the outstanding limit is reached
  always_comb begin
    elig[0] = ic_req_valid_i;
    elig[1] = dr_req_valid_i;
    elig[2] = dw_req_valid_i && (store_cnt_q < CntWidth'(MaxOutstandingStores));
  end

  // First eligible requester searching from the pointer, wrapping IC->DR->DW
  always_comb begin
    winner   = SrcIc;
    any_elig = |elig;
    case (rr_ptr_q)
      SrcDr: begin
        if (elig[1])      winner = SrcDr;
        else if (elig[2]) winner = SrcDw;
        else              winner = SrcIc;
      end
      SrcDw: begin
        if (elig[2])      winner = SrcDw;
        else if (elig[0]) winner = SrcIc;
        else              winner = SrcDr;
      end
      default: begin
        if (elig[0])      winner = SrcIc;
        else if (elig[1]) winner = SrcDr;
        else              winner = SrcDw;
      end
    endcase
  end

  // Grant only when the output register can accept a new request
  always_comb begin
    load_en        = !mem_req_valid_o || mem_req_ready_i;
    grant          = load_en && any_elig && !rst_i;
    ic_req_ready_o = grant && (winner == SrcIc);
    dr_req_ready_o = grant && (winner == SrcDr);
    dw_req_ready_o = grant && (winner == SrcDw);
    rr_ptr_d       = rr_ptr_q;
    if (grant) rr_ptr_d = (winner == SrcDw) ? SrcIc : winner + 2'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rr_ptr_q <= SrcIc;
    else       rr_ptr_q <= rr_ptr_d;
  end

  // Registered request stage; held stable while memory back-pressures
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_req_valid_o <= 1'b0;
      mem_req_src_o   <= 2'd0;
      mem_req_we_o    <= 1'b0;
      mem_req_addr_o  <= '0;
      mem_req_data_o  <= '0;
      mem_req_be_o    <= '0;
      mem_req_tid_o   <= '0;
    end else if (grant) begin
      mem_req_valid_o <= 1'b1;
      mem_req_src_o   <= winner;
      mem_req_we_o    <= (winner == SrcDw);
      case (winner)
        SrcDr: begin
          mem_req_addr_o <= dr_req_addr_i;
          mem_req_data_o <= '0;
          mem_req_be_o   <= '0;
          mem_req_tid_o  <= dr_req_tid_i;
        end
        SrcDw: begin
          mem_req_addr_o <= dw_req_addr_i;
          mem_req_data_o <= dw_req_data_i;
          mem_req_be_o   <= dw_req_be_i;
          mem_req_tid_o  <= dw_req_tid_i;
        end
        default: begin
          mem_req_addr_o <= ic_req_addr_i;
          mem_req_data_o <= '0;
          mem_req_be_o   <= BeWidth'(0);
          mem_req_tid_o  <= ic_req_tid_i;
        end
      endcase
    end else if (mem_req_ready_i) begin
      mem_req_valid_o <= 1'b0;
    end
  end

  // Outstanding-store count; a stray ack at zero is ignored
  always_comb begin
    store_inc = grant && (winner == SrcDw);
    store_ack = mem_rtrn_valid_i && (mem_rtrn_src_i == SrcDw);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      store_cnt_q <= '0;
    end else if (store_inc && !store_ack) begin
      store_cnt_q <= store_cnt_q + CntWidth'(1);
    end else if (!store_inc && store_ack && (store_cnt_q != '0)) begin
      store_cnt_q <= store_cnt_q - CntWidth'(1);
    end
  end

  // Response demux; source 3 is not a requester and is dropped
  always_comb begin
    ic_rtrn_valid_o = !rst_i && mem_rtrn_valid_i && (mem_rtrn_src_i == SrcIc);
    dr_rtrn_valid_o = !rst_i && mem_rtrn_valid_i && (mem_rtrn_src_i == SrcDr);
    dw_ack_o        = !rst_i && store_ack;
    store_cnt_o     = store_cnt_q;
    stores_idle_o   = (store_cnt_q == '0) && !(mem_req_valid_o && mem_req_we_o);
  end

  // Protocol checks on the return path
  always @(posedge clk_i) begin
    if (!rst_i && mem_rtrn_valid_i) begin
      assert (!(store_ack && (store_cnt_q == '0)))
        else $warning("store ack received with no outstanding store");
      assert (mem_rtrn_src_i != 2'd3)
        else $warning("response with reserved source 3 dropped");
    end
    if (!rst_i) begin
      assert (store_cnt_q <= CntWidth'(MaxOutstandingStores))
        else $error("outstanding store count above limit");
    end
  end

endmodule

// File: tb/tb_l1_mem_req_arbiter.sv
module tb_l1_mem_req_arbiter;

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;
  localparam int unsigned TW = 2;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          ic_req_valid_i, ic_req_ready_o;
  logic [AW-1:0] ic_req_addr_i;
  logic [TW-1:0] ic_req_tid_i;
  logic          dr_req_valid_i, dr_req_ready_o;
  logic [AW-1:0] dr_req_addr_i;
  logic [TW-1:0] dr_req_tid_i;
  logic          dw_req_valid_i, dw_req_ready_o;
  logic [AW-1:0] dw_req_addr_i;
  logic [DW-1:0] dw_req_data_i;
  logic [DW/8-1:0] dw_req_be_i;
  logic [TW-1:0] dw_req_tid_i;
  logic          mem_req_valid_o, mem_req_ready_i;
  logic [1:0]    mem_req_src_o;
  logic          mem_req_we_o;
  logic [AW-1:0] mem_req_addr_o;
  logic [DW-1:0] mem_req_data_o;
  logic [DW/8-1:0] mem_req_be_o;
  logic [TW-1:0] mem_req_tid_o;
  logic          mem_rtrn_valid_i;
  logic [1:0]    mem_rtrn_src_i;
  logic          ic_rtrn_valid_o, dr_rtrn_valid_o, dw_ack_o;
  logic [7:0]    store_cnt_o;
  logic          stores_idle_o;

  int total = 0;
  int bad   = 0;

  l1_mem_req_arbiter #(
    .AddrWidth(AW), .DataWidth(DW), .TidWidth(TW), .MaxOutstandingStores(7)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ic_req_valid_i(ic_req_valid_i), .ic_req_ready_o(ic_req_ready_o),
    .ic_req_addr_i(ic_req_addr_i), .ic_req_tid_i(ic_req_tid_i),
    .dr_req_valid_i(dr_req_valid_i), .dr_req_ready_o(dr_req_ready_o),
    .dr_req_addr_i(dr_req_addr_i), .dr_req_tid_i(dr_req_tid_i),
    .dw_req_valid_i(dw_req_valid_i), .dw_req_ready_o(dw_req_ready_o),
    .dw_req_addr_i(dw_req_addr_i), .dw_req_data_i(dw_req_data_i),
    .dw_req_be_i(dw_req_be_i), .dw_req_tid_i(dw_req_tid_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_src_o(mem_req_src_o), .mem_req_we_o(mem_req_we_o),
    .mem_req_addr_o(mem_req_addr_o), .mem_req_data_o(mem_req_data_o),
    .mem_req_be_o(mem_req_be_o), .mem_req_tid_o(mem_req_tid_o),
    .mem_rtrn_valid_i(mem_rtrn_valid_i), .mem_rtrn_src_i(mem_rtrn_src_i),
    .ic_rtrn_valid_o(ic_rtrn_valid_o), .dr_rtrn_valid_o(dr_rtrn_valid_o),
    .dw_ack_o(dw_ack_o), .store_cnt_o(store_cnt_o), .stores_idle_o(stores_idle_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs;
    ic_req_valid_i   = 1'b0;
    dr_req_valid_i   = 1'b0;
    dw_req_valid_i   = 1'b0;
    mem_req_ready_i  = 1'b1;
    mem_rtrn_valid_i = 1'b0;
    mem_rtrn_src_i   = 2'd0;
  endtask

  task automatic set_payloads;
    ic_req_addr_i = 64'h0000_1000; ic_req_tid_i = 2'd0;
    dr_req_addr_i = 64'h0000_2000; dr_req_tid_i = 2'd1;
    dw_req_addr_i = 64'h0000_3000; dw_req_tid_i = 2'd3;
    dw_req_data_i = 64'hDEAD_BEEF_0123_4567; dw_req_be_i = 8'h0F;
  endtask

  task automatic do_reset;
    clear_inputs();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset;
    set_payloads();
    clear_inputs();
    rst_i = 1'b1;
    ic_req_valid_i = 1'b1; dr_req_valid_i = 1'b1; dw_req_valid_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if ({ic_req_ready_o, dr_req_ready_o, dw_req_ready_o} !== 3'b000) begin
        bad++; $display("FAIL reset_ready: got %b want 000", {ic_req_ready_o, dr_req_ready_o, dw_req_ready_o});
      end
      total++;
      if (mem_req_valid_o !== 1'b0 || mem_req_addr_o !== 64'h0) begin
        bad++; $display("FAIL reset_req: valid=%b addr=%h want 0/0", mem_req_valid_o, mem_req_addr_o);
      end
      total++;
      if (store_cnt_o !== 8'd0 || stores_idle_o !== 1'b1) begin
        bad++; $display("FAIL reset_cnt: cnt=%0d idle=%b want 0/1", store_cnt_o, stores_idle_o);
      end
    end
    rst_i = 1'b0;
    #1;
    total++;
    if ({ic_req_ready_o, dr_req_ready_o, dw_req_ready_o} !== 3'b100) begin
      bad++; $display("FAIL first_grant_ic: got %b want 100", {ic_req_ready_o, dr_req_ready_o, dw_req_ready_o});
    end
    tick();
    total++;
    if (mem_req_valid_o !== 1'b1 || mem_req_src_o !== 2'd0 || mem_req_addr_o !== 64'h1000) begin
      bad++; $display("FAIL first_issue: valid=%b src=%0d addr=%h want 1/0/1000", mem_req_valid_o, mem_req_src_o, mem_req_addr_o);
    end
    clear_inputs();
  endtask

  task automatic test_round_robin;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    logic [7:0]    exp_be;
    logic [1:0]    exp_tid;
    int            exp;
    do_reset();
    set_payloads();
    ic_req_valid_i = 1'b1; dr_req_valid_i = 1'b1; dw_req_valid_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp = i % 3;
      #1;
      total++;
      if ({ic_req_ready_o, dr_req_ready_o, dw_req_ready_o} !== (3'b100 >> exp)) begin
        bad++; $display("FAIL rr_ready[%0d]: got %b want %b", i, {ic_req_ready_o, dr_req_ready_o, dw_req_ready_o}, 3'b100 >> exp);
      end
      tick();
      case (exp)
        0: begin exp_addr = 64'h1000; exp_data = 64'h0; exp_be = 8'h00; exp_tid = 2'd0; end
        1: begin exp_addr = 64'h2000; exp_data = 64'h0; exp_be = 8'h00; exp_tid = 2'd1; end
        default: begin exp_addr = 64'h3000; exp_data = 64'hDEAD_BEEF_0123_4567; exp_be = 8'h0F; exp_tid = 2'd3; end
      endcase
      total++;
      if (mem_req_valid_o !== 1'b1 || mem_req_src_o !== 2'(exp) || mem_req_we_o !== (exp == 2)
          || mem_req_addr_o !== exp_addr || mem_req_data_o !== exp_data
          || mem_req_be_o !== exp_be || mem_req_tid_o !== exp_tid) begin
        bad++;
        $display("FAIL rr_issue[%0d]: v=%b src=%0d we=%b addr=%h data=%h be=%h tid=%0d want src=%0d addr=%h data=%h be=%h tid=%0d",
                 i, mem_req_valid_o, mem_req_src_o, mem_req_we_o, mem_req_addr_o, mem_req_data_o,
                 mem_req_be_o, mem_req_tid_o, exp, exp_addr, exp_data, exp_be, exp_tid);
      end
    end
    clear_inputs();
  endtask

  task automatic test_backpressure;
    do_reset();
    set_payloads();
    dr_req_valid_i = 1'b1; dr_req_addr_i = 64'h8000_0040; dr_req_tid_i = 2'd2;
    mem_req_ready_i = 1'b0;
    tick();
    dr_req_valid_i = 1'b0;
    ic_req_valid_i = 1'b1; dw_req_valid_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      total++;
      if ({ic_req_ready_o, dr_req_ready_o, dw_req_ready_o} !== 3'b000) begin
        bad++; $display("FAIL stall_ready[%0d]: got %b want 000", c, {ic_req_ready_o, dr_req_ready_o, dw_req_ready_o});
      end
      total++;
      if (mem_req_valid_o !== 1'b1 || mem_req_src_o !== 2'd1 || mem_req_we_o !== 1'b0
          || mem_req_addr_o !== 64'h8000_0040 || mem_req_tid_o !== 2'd2) begin
        bad++; $display("FAIL stall_hold[%0d]: v=%b src=%0d addr=%h tid=%0d want 1/1/80000040/2",
                        c, mem_req_valid_o, mem_req_src_o, mem_req_addr_o, mem_req_tid_o);
      end
      tick();
    end
    mem_req_ready_i = 1'b1;
    #1;
    total++;
    if ({ic_req_ready_o, dr_req_ready_o, dw_req_ready_o} !== 3'b001) begin
      bad++; $display("FAIL release_ready: got %b want 001", {ic_req_ready_o, dr_req_ready_o, dw_req_ready_o});
    end
    tick();
    total++;
    if (mem_req_valid_o !== 1'b1 || mem_req_src_o !== 2'd2 || mem_req_addr_o !== 64'h3000) begin
      bad++; $display("FAIL release_issue: v=%b src=%0d addr=%h want 1/2/3000", mem_req_valid_o, mem_req_src_o, mem_req_addr_o);
    end
    clear_inputs();
  endtask

  task automatic test_store_throttle;
    int exp_cnt;
    do_reset();
    set_payloads();
    dw_req_valid_i = 1'b1;
    for (int j = 0; j < 9; j++) begin
      exp_cnt = (j < 7) ? j : 7;
      #1;
      total++;
      if (store_cnt_o !== 8'(exp_cnt) || dw_req_ready_o !== (j < 7)) begin
        bad++; $display("FAIL throttle[%0d]: cnt=%0d ready=%b want %0d/%b", j, store_cnt_o, dw_req_ready_o, exp_cnt, j < 7);
      end
      tick();
    end
    mem_rtrn_valid_i = 1'b1; mem_rtrn_src_i = 2'd2;
    #1;
    total++;
    if (store_cnt_o !== 8'd7 || dw_req_ready_o !== 1'b0 || dw_ack_o !== 1'b1) begin
      bad++; $display("FAIL throttle_full_ack: cnt=%0d ready=%b ack=%b want 7/0/1", store_cnt_o, dw_req_ready_o, dw_ack_o);
    end
    tick();
    #1;
    total++;
    if (store_cnt_o !== 8'd6 || dw_req_ready_o !== 1'b1 || dw_ack_o !== 1'b1) begin
      bad++; $display("FAIL throttle_regrant: cnt=%0d ready=%b ack=%b want 6/1/1", store_cnt_o, dw_req_ready_o, dw_ack_o);
    end
    tick();
    total++;
    if (store_cnt_o !== 8'd6) begin
      bad++; $display("FAIL throttle_grant_ack: cnt=%0d want 6", store_cnt_o);
    end
    clear_inputs();
  endtask

  task automatic test_simultaneous;
    do_reset();
    set_payloads();
    dw_req_valid_i = 1'b1;
    repeat (3) tick();
    total++;
    if (store_cnt_o !== 8'd3) begin
      bad++; $display("FAIL sim_setup: cnt=%0d want 3", store_cnt_o);
    end
    mem_rtrn_valid_i = 1'b1; mem_rtrn_src_i = 2'd2;
    #1;
    total++;
    if (dw_req_ready_o !== 1'b1 || dw_ack_o !== 1'b1) begin
      bad++; $display("FAIL sim_both: ready=%b ack=%b want 1/1", dw_req_ready_o, dw_ack_o);
    end
    tick();
    total++;
    if (store_cnt_o !== 8'd3) begin
      bad++; $display("FAIL sim_cnt: cnt=%0d want 3", store_cnt_o);
    end
    do_reset();
    mem_rtrn_valid_i = 1'b1; mem_rtrn_src_i = 2'd2;
    #1;
    total++;
    if ({ic_rtrn_valid_o, dr_rtrn_valid_o, dw_ack_o} !== 3'b001) begin
      bad++; $display("FAIL ack_zero_route: got %b want 001", {ic_rtrn_valid_o, dr_rtrn_valid_o, dw_ack_o});
    end
    tick();
    total++;
    if (store_cnt_o !== 8'd0) begin
      bad++; $display("FAIL ack_zero_cnt: cnt=%0d want 0", store_cnt_o);
    end
    for (int s = 0; s < 4; s++) begin
      mem_rtrn_src_i = 2'(s);
      #1;
      total++;
      if ({ic_rtrn_valid_o, dr_rtrn_valid_o, dw_ack_o} !== ((s == 3) ? 3'b000 : (3'b100 >> s))) begin
        bad++; $display("FAIL route_src%0d: got %b want %b", s, {ic_rtrn_valid_o, dr_rtrn_valid_o, dw_ack_o},
                        (s == 3) ? 3'b000 : (3'b100 >> s));
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_mid_reset;
    do_reset();
    set_payloads();
    mem_req_ready_i = 1'b0;
    dw_req_valid_i  = 1'b1;
    tick();
    #2;
    rst_i = 1'b1;
    #1;
    total++;
    if (mem_req_valid_o !== 1'b0 || store_cnt_o !== 8'd0 || stores_idle_o !== 1'b1
        || {ic_req_ready_o, dr_req_ready_o, dw_req_ready_o} !== 3'b000) begin
      bad++; $display("FAIL mid_reset: v=%b cnt=%0d idle=%b rdy=%b want 0/0/1/000", mem_req_valid_o, store_cnt_o,
                      stores_idle_o, {ic_req_ready_o, dr_req_ready_o, dw_req_ready_o});
    end
    clear_inputs();
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_fence;
    do_reset();
    set_payloads();
    dw_req_valid_i = 1'b1;
    #1;
    total++;
    if (stores_idle_o !== 1'b1 || dw_req_ready_o !== 1'b1) begin
      bad++; $display("FAIL fence_pre: idle=%b ready=%b want 1/1", stores_idle_o, dw_req_ready_o);
    end
    tick();
    dw_req_valid_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      total++;
      if (stores_idle_o !== 1'b0) begin
        bad++; $display("FAIL fence_busy[%0d]: idle=%b want 0", c, stores_idle_o);
      end
      tick();
    end
    mem_rtrn_valid_i = 1'b1; mem_rtrn_src_i = 2'd2;
    #1;
    total++;
    if (stores_idle_o !== 1'b0 || dw_ack_o !== 1'b1) begin
      bad++; $display("FAIL fence_ack_cycle: idle=%b ack=%b want 0/1", stores_idle_o, dw_ack_o);
    end
    tick();
    mem_rtrn_valid_i = 1'b0;
    #1;
    total++;
    if (stores_idle_o !== 1'b1 || store_cnt_o !== 8'd0) begin
      bad++; $display("FAIL fence_done: idle=%b cnt=%0d want 1/0", stores_idle_o, store_cnt_o);
    end
    clear_inputs();
  endtask

  initial begin
    rst_i = 1'b1;
    set_payloads();
    clear_inputs();
    test_reset();
    test_round_robin();
    test_backpressure();
    test_store_throttle();
    test_simultaneous();
    test_mid_reset();
    test_fence();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/l1_mem_req_arbiter.md
Name: l1_mem_req_arbiter

Overview:
- Shares the single L1-to-memory request port between three requesters: I-cache refill, D-cache read miss, and D-cache write-buffer store.
- Round-robin arbitration into a registered output stage.
- Throttles stores to a configured number of outstanding stores.
- Demultiplexes returning responses back to the requester that issued them.
- Sits between the write-through L1 caches and the memory adapter.

Parameters:
- AddrWidth, 64, request address width.
- DataWidth, 64, store data width; byte-enable width is DataWidth/8.
- TidWidth, 2, transaction ID width carried through unchanged.
- MaxOutstandingStores, 7, maximum stores issued but not yet acknowledged; legal range 1..255.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- ic_req_valid_i / ic_req_ready_o  in/out  1  I-cache request handshake.
- ic_req_addr_i  in  AddrWidth  I-cache line address.
- ic_req_tid_i  in  TidWidth  I-cache transaction ID.
- dr_req_valid_i / dr_req_ready_o  in/out  1  D-cache read-miss handshake.
- dr_req_addr_i  in  AddrWidth  D-cache read-miss address.
- dr_req_tid_i  in  TidWidth  D-cache read-miss transaction ID.
- dw_req_valid_i / dw_req_ready_o  in/out  1  store handshake.
- dw_req_addr_i  in  AddrWidth  store address.
- dw_req_data_i  in  DataWidth  store data.
- dw_req_be_i  in  DataWidth/8  store byte enables.
- dw_req_tid_i  in  TidWidth  store transaction ID.
- mem_req_valid_o / mem_req_ready_i  out/in  1  memory request handshake.
- mem_req_src_o  out  2  source of the request: 0 = IC, 1 = DR, 2 = DW.
- mem_req_we_o  out  1  1 = store.
- mem_req_addr_o  out  AddrWidth  request address.
- mem_req_data_o  out  DataWidth  request data.
- mem_req_be_o  out  DataWidth/8  request byte enables.
- mem_req_tid_o  out  TidWidth  request transaction ID.
- mem_rtrn_valid_i  in  1  response valid.
- mem_rtrn_src_i  in  2  source the response belongs to.
- ic_rtrn_valid_o  out  1  response valid to I-cache.
- dr_rtrn_valid_o  out  1  response valid to D-cache read path.
- dw_ack_o  out  1  store acknowledge to the write buffer.
- store_cnt_o  out  8  current outstanding-store count.
- stores_idle_o  out  1  no store pending or outstanding; used by fences.

Behaviour:
- Reset values:
  - mem_req_valid_o = 0.
  - All mem_req_* payload outputs = 0.
  - Round-robin pointer = 0, so IC has highest priority.
  - store_cnt_o = 0.
  - stores_idle_o = 1.
  - All *_ready_o and *_rtrn/ack outputs = 0 while rst_i is high.
- Reset mid-operation drops the held request and clears the store count; no in-flight state is preserved.
- Output register:
  - load_en = !mem_req_valid_o || mem_req_ready_i.
  - A request is granted only when load_en = 1.
  - Issue latency is 1 cycle from grant; full throughput, one request per cycle when mem_req_ready_i stays high.
  - While mem_req_valid_o = 1 and mem_req_ready_i = 0, all outputs stay stable.
- Eligibility:
  - IC is eligible when ic_req_valid_i = 1.
  - DR is eligible when dr_req_valid_i = 1.
  - DW is eligible when dw_req_valid_i = 1 and store_cnt < MaxOutstandingStores.
- Arbitration:
  - Search order starts at the pointer: IC(0) -> DR(1) -> DW(2), wrapping back to 0.
  - The first eligible requester wins.
  - Its ready_o is asserted combinationally in the same cycle; at most one ready_o is high per cycle.
  - On grant, pointer = (winner + 1) mod 3.
  - With no grant, the pointer holds.
- Payload for IC/DR grants: mem_req_we_o = 0, data = 0, be = 0.
- Store counter:
  - Increments on a DW grant.
  - Decrements on mem_rtrn_valid_i && mem_rtrn_src_i == 2.
  - A grant and an ack in the same cycle leave the count unchanged.
  - An ack when the count is 0 leaves the count at 0 and fires a simulation assertion.
  - The count never exceeds MaxOutstandingStores.
- Response routing (combinational, no added latency):
  - ic_rtrn_valid_o = mem_rtrn_valid_i && src == 0.
  - dr_rtrn_valid_o = mem_rtrn_valid_i && src == 1.
  - dw_ack_o = mem_rtrn_valid_i && src == 2.
  - src == 3 is dropped and fires an assertion.
- stores_idle_o = (store_cnt == 0) && !(mem_req_valid_o && mem_req_we_o).
- Requesters must hold valid and payload until they see ready; the arbiter does not re-check payload stability.

Test Plan:
- Reset: rst_i held high for 3 cycles with all valids high -> all ready_o = 0, mem_req_valid_o = 0, store_cnt_o = 0, stores_idle_o = 1. After release, the first grant goes to IC.
- Round-robin: all three valid continuously, mem_req_ready_i = 1 -> mem_req_src_o sequence 0,1,2,0,1,2, one request per cycle, each starting the cycle after its grant.
- Backpressure: mem_req_ready_i = 0 for 5 cycles with DR request addr 0x8000_0040, tid 2 latched -> outputs stable for 5 cycles, no ready_o asserted. Ready returns -> the next winner is loaded the same cycle.
- Store throttle: 9 back-to-back DW requests with no acks -> 7 granted, store_cnt_o = 7, dw_req_ready_o stays 0. One ack (src = 2) -> count 6, the next store is granted, and in the same cycle as a further ack the count stays 6.
- Simultaneous and error cases:
  - DW grant and ack in the same cycle at count 3 -> count stays 3.
  - Ack at count 0 -> count stays 0, assertion fires.
  - src = 3 response -> no rtrn/ack output.
- Fence idle: one store issued then acked -> stores_idle_o goes 1 -> 0 on the grant cycle and stays 0 until the ack cycle. It returns to 1 the cycle after the ack.
